// File: rtl/mig_burst_pkg.sv
// Shared encodings for the MIG burst engine: FSM states and MIG app_cmd opcodes.
package mig_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mig_burst_engine.sv
// MIG app-interface burst engine (ui_clk domain): runs one host command at a time, either a
// write burst from the input FIFO to DDR or a read burst from DDR into the output FIFO.
module mig_burst_engine
    import mig_burst_pkg::*;
#(
    parameter int APP_DATA_W = 256,
    parameter int APP_ADDR_W = 30,
    parameter int ADDR_INC   = 8,
    parameter int LEN_W      = 16,
    parameter int MAX_RD_OUT = 32,
    parameter int CNT_W      = 8
) (
    input  logic                    sys_clk,
    input  logic                    rstn,
    input  logic                    calib_done,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [APP_ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]        cmd_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err_unexp_rd,
    output logic                    err_ob_ovf,

    output logic                    ib_re,
    input  logic [APP_DATA_W-1:0]   ib_data,
    input  logic                    ib_empty,

    output logic                    ob_we,
    output logic [APP_DATA_W-1:0]   ob_data,
    input  logic                    ob_full,
    input  logic [CNT_W-1:0]        ob_free,

    input  logic                    app_rdy,
    input  logic                    app_wdf_rdy,
    input  logic [APP_DATA_W-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    input  logic                    app_rd_data_end,
    output logic                    app_en,
    output logic [2:0]              app_cmd,
    output logic [APP_ADDR_W-1:0]   app_addr,
    output logic                    app_wdf_wren,
    output logic [APP_DATA_W-1:0]   app_wdf_data,
    output logic                    app_wdf_end,
    output logic [APP_DATA_W/8-1:0] app_wdf_mask,

    output state_t                  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid (cmd_valid, app_en,
    // app_wdf_wren) and ready (cmd_ready, app_rdy, app_wdf_rdy) are both high; a raised
    // valid and its payload stay put until that edge.

    localparam logic [CNT_W-1:0]      MAX_RD = CNT_W'(MAX_RD_OUT);
    localparam logic [APP_ADDR_W-1:0] A_INC  = APP_ADDR_W'(ADDR_INC);

    state_t                  state;
    logic [APP_ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]        rem_q;
    logic [CNT_W-1:0]        infl_q;
    logic                    cmd_sent;
    logic                    data_sent;

    logic wr_en;
    logic wr_wren;
    logic rd_en;
    logic cmd_acc;
    logic dat_acc;
    logic beat_done;
    logic rd_issue;
    logic rd_ret;

    always_comb begin
        wr_en     = (state == ST_WR) && !cmd_sent && !ib_empty;
        wr_wren   = (state == ST_WR) && !data_sent && !ib_empty;
        rd_en     = (state == ST_RD) && (rem_q != '0) && (infl_q < MAX_RD) && (infl_q < ob_free);
        cmd_acc   = wr_en && app_rdy;
        dat_acc   = wr_wren && app_wdf_rdy;
        // Command and data may be taken in different cycles; the beat retires once both are in.
        beat_done = (state == ST_WR) && (cmd_sent || cmd_acc) && (data_sent || dat_acc);
        rd_issue  = rd_en && app_rdy;
        // In 4:1 mode every valid beat is also its own burst end.
        rd_ret    = app_rd_data_valid && app_rd_data_end;
    end

    assign cmd_ready    = (state == ST_IDLE) && calib_done;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign dbg_state    = state;

    assign app_en       = wr_en || rd_en;
    assign app_cmd      = (state == ST_RD) ? CMD_READ : CMD_WRITE;
    assign app_addr     = addr_q;
    assign app_wdf_wren = wr_wren;
    assign app_wdf_end  = wr_wren;
    assign app_wdf_data = wr_wren ? ib_data : '0;
    assign app_wdf_mask = '0;
    assign ib_re        = beat_done;

    assign ob_we        = app_rd_data_valid;
    assign ob_data      = app_rd_data;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            infl_q       <= '0;
            cmd_sent     <= 1'b0;
            data_sent    <= 1'b0;
            err_unexp_rd <= 1'b0;
            err_ob_ovf   <= 1'b0;
        end else begin
            if (app_rd_data_valid && (infl_q == '0))
                err_unexp_rd <= 1'b1;
            if (app_rd_data_valid && ob_full)
                err_ob_ovf <= 1'b1;

            // Issue and return in the same cycle cancel; a stray return saturates at zero.
            if (rd_issue && !rd_ret)
                infl_q <= infl_q + 1'b1;
            else if (rd_ret && !rd_issue && (infl_q != '0))
                infl_q <= infl_q - 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q    <= cmd_addr;
                        rem_q     <= cmd_len;
                        cmd_sent  <= 1'b0;
                        data_sent <= 1'b0;
                        if (cmd_len == '0)
                            state <= ST_DONE;
                        else if (cmd_write)
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                ST_WR: begin
                    if (beat_done) begin
                        addr_q    <= addr_q + A_INC;
                        rem_q     <= rem_q - 1'b1;
                        cmd_sent  <= 1'b0;
                        data_sent <= 1'b0;
                        if (rem_q == LEN_W'(1))
                            state <= ST_DONE;
                    end else begin
                        if (cmd_acc)
                            cmd_sent <= 1'b1;
                        if (dat_acc)
                            data_sent <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (rd_issue) begin
                        addr_q <= addr_q + A_INC;
                        rem_q  <= rem_q - 1'b1;
                    end
                    if ((rem_q == '0) && (infl_q == '0))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mig_burst_engine.sv
// Bench for mig_burst_engine: MIG BFM with random stalls and 20-cycle read latency,
// host FIFO models, and an expected-data scoreboard.
module tb_mig_burst_engine;
    import mig_burst_pkg::*;

    localparam int DW     = 256;
    localparam int AW     = 30;
    localparam int LW     = 16;
    localparam int CW     = 8;
    localparam int RD_LAT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic            calib_done;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic            busy;
    logic            done;
    logic            err_unexp_rd;
    logic            err_ob_ovf;
    logic            ib_re;
    logic [DW-1:0]   ib_data;
    logic            ib_empty;
    logic            ob_we;
    logic [DW-1:0]   ob_data;
    logic            ob_full;
    logic [CW-1:0]   ob_free;
    logic            app_rdy;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic            app_rd_data_end;
    logic            app_en;
    logic [2:0]      app_cmd;
    logic [AW-1:0]   app_addr;
    logic            app_wdf_wren;
    logic [DW-1:0]   app_wdf_data;
    logic            app_wdf_end;
    logic [DW/8-1:0] app_wdf_mask;
    state_t          dbg_state;

    logic            bfm_rv;
    logic [DW-1:0]   bfm_rd;
    logic            spur_rv;
    logic [DW-1:0]   spur_data;
    logic            ib_hold;
    logic            pop_ib;

    assign app_rd_data_valid = (bfm_rv && rstn) || spur_rv;
    assign app_rd_data       = spur_rv ? spur_data : bfm_rd;
    assign app_rd_data_end   = app_rd_data_valid;

    mig_burst_engine dut (
        .sys_clk(clk), .rstn(rstn), .calib_done(calib_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done),
        .err_unexp_rd(err_unexp_rd), .err_ob_ovf(err_ob_ovf),
        .ib_re(ib_re), .ib_data(ib_data), .ib_empty(ib_empty),
        .ob_we(ob_we), .ob_data(ob_data), .ob_full(ob_full), .ob_free(ob_free),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
        .dbg_state(dbg_state)
    );

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rd_ent_t;

    logic [DW-1:0]   exp_q[$];
    logic [AW+2:0]   addr_q[$];
    logic [DW-1:0]   ib_q[$];
    logic [AW-1:0]   wa_q[$];
    logic [DW-1:0]   wd_q[$];
    rd_ent_t         rd_pipe[$];
    logic [DW-1:0]   bfm_mem[logic [AW-1:0]];
    logic [DW-1:0]   tb_mem[logic [AW-1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_app_cmd, n_ib_re, n_ob_we, n_done, n_rd_acc, infl, max_infl;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        n_app_cmd = 0; n_ib_re = 0; n_ob_we = 0; n_done = 0;
        n_rd_acc = 0; infl = 0; max_infl = 0;
    endtask

    // MIG/FIFO driver: changes inputs 1 time unit after the rising edge.
    initial begin
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; ib_hold = 1'b0; pop_ib = 1'b0;
        bfm_rv = 1'b0; bfm_rd = '0; ib_empty = 1'b1; ib_data = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rstn) begin
                rd_pipe.delete();
                pop_ib = 1'b0;
            end
            if (pop_ib) begin
                if (ib_q.size() > 0) void'(ib_q.pop_front());
                pop_ib = 1'b0;
            end
            app_rdy     = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 3) != 0);
            ib_hold     = ($urandom_range(0, 7) == 0);
            ib_empty    = (ib_q.size() == 0) || ib_hold;
            ib_data     = (ib_q.size() > 0) ? ib_q[0] : '0;
            if (rd_pipe.size() > 0 && rd_pipe[0].due <= cyc) begin
                bfm_rv = 1'b1;
                bfm_rd = rd_pipe[0].data;
                void'(rd_pipe.pop_front());
            end else begin
                bfm_rv = 1'b0;
            end
        end
    end

    // Monitor and scoreboard: samples on the falling edge.
    initial begin
        logic [AW+2:0] e;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        rd_ent_t       ent;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (app_en && app_rdy) begin
                    n_app_cmd++;
                    if (addr_q.size() == 0) begin
                        check("app_cmd_extra", 1, 0);
                    end else begin
                        e = addr_q.pop_front();
                        check("app_cmd_addr", {app_cmd, app_addr}, e);
                    end
                    if (app_cmd == CMD_WRITE) wa_q.push_back(app_addr);
                    if (app_cmd == CMD_READ) begin
                        n_rd_acc++;
                        infl++;
                        if (infl > max_infl) max_infl = infl;
                        ent.due  = cyc + RD_LAT;
                        ent.data = bfm_mem.exists(app_addr) ? bfm_mem[app_addr] : '0;
                        rd_pipe.push_back(ent);
                    end
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    check("wdf_end", app_wdf_end, 1);
                    wd_q.push_back(app_wdf_data);
                end
                while (wa_q.size() > 0 && wd_q.size() > 0) begin
                    wa = wa_q.pop_front();
                    wd = wd_q.pop_front();
                    bfm_mem[wa] = wd;
                end
                if (ib_re) begin
                    n_ib_re++;
                    pop_ib = 1'b1;
                end
                if (ob_we && !spur_rv) begin
                    n_ob_we++;
                    if (infl > 0) infl--;
                    if (exp_q.size() == 0) check("ob_unexpected", 1, 0);
                    else check("ob_data", ob_data, exp_q.pop_front());
                end
                if (done) n_done++;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int t;
        @(posedge clk); #2;
        a = addr;
        for (int i = 0; i < len; i++) begin
            if (wr) begin
                for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
                ib_q.push_back(d);
                tb_mem[a] = d;
                addr_q.push_back({CMD_WRITE, a});
            end else begin
                exp_q.push_back(tb_mem.exists(a) ? tb_mem[a] : '0);
                addr_q.push_back({CMD_READ, a});
            end
            a = a + AW'(8);
        end
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 200);
        check("cmd_accept", cmd_ready, 1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 3000);
        check("done_seen", done, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [AW-1:0] ra;
        int rl;
        rstn = 1'b0; calib_done = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_len = '0; ob_full = 1'b0; ob_free = CW'(64);
        spur_rv = 1'b0; spur_data = '0;
        clr_stats();

        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_mask", app_wdf_mask, 0);
        check("rst_errs", {err_unexp_rd, err_ob_ovf}, 0);
        @(posedge clk); #2 rstn = 1'b1;
        @(negedge clk);
        check("nocal_cmd_ready", cmd_ready, 0);
        @(posedge clk); #2 calib_done = 1'b1;
        @(negedge clk);
        check("cal_cmd_ready", cmd_ready, 1);

        // Write burst of 4 at 0x100
        clr_stats();
        send_cmd(1'b1, AW'(30'h100), 4);
        wait_done(lat);
        check("t1_ib_re", n_ib_re, 4);
        check("t1_app_cmds", n_app_cmd, 4);
        check("t1_done_cnt", n_done, 1);
        check("t1_addr_left", addr_q.size(), 0);

        // Read back
        clr_stats();
        send_cmd(1'b0, AW'(30'h100), 4);
        wait_done(lat);
        check("t2_ob_we", n_ob_we, 4);
        check("t2_exp_left", exp_q.size(), 0);
        check("t2_inflight", infl, 0);
        check("t2_done_cnt", n_done, 1);

        // Zero length
        clr_stats();
        send_cmd(1'b1, AW'(30'h300), 0);
        wait_done(lat);
        check("t3_done_lat_ok", (lat >= 1 && lat <= 2), 1);
        check("t3_traffic", n_app_cmd + n_ib_re + n_ob_we, 0);
        check("t3_done_cnt", n_done, 1);

        // Output FIFO credit limit
        clr_stats();
        send_cmd(1'b1, AW'(30'h200), 8);
        wait_done(lat);
        clr_stats();
        ob_free = CW'(2);
        send_cmd(1'b0, AW'(30'h200), 8);
        wait_done(lat);
        check("t4_max_inflight_le2", (max_infl <= 2), 1);
        check("t4_ob_we", n_ob_we, 8);
        check("t4_ovf", err_ob_ovf, 0);
        ob_free = CW'(64);

        // Address wrap
        clr_stats();
        send_cmd(1'b1, AW'(30'h3FFFFFF0), 4);
        wait_done(lat);
        check("t5_addr_left", addr_q.size(), 0);
        clr_stats();
        send_cmd(1'b0, AW'(30'h3FFFFFF0), 4);
        wait_done(lat);
        check("t5_ob_we", n_ob_we, 4);

        // Random write/read pairs
        for (int it = 0; it < 4; it++) begin
            ra = AW'({$urandom_range(512, 767), 3'b000});
            rl = $urandom_range(1, 6);
            clr_stats();
            send_cmd(1'b1, ra, rl);
            wait_done(lat);
            check("rnd_ib_re", n_ib_re, rl);
            clr_stats();
            send_cmd(1'b0, ra, rl);
            wait_done(lat);
            check("rnd_ob_we", n_ob_we, rl);
        end

        // Reset during read beat 3 of 8
        clr_stats();
        send_cmd(1'b0, AW'(30'h100), 8);
        lat = 0;
        while (n_rd_acc < 3 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check("t6_beat3_reached", (n_rd_acc >= 3), 1);
        @(posedge clk); #2;
        rstn = 1'b0;
        calib_done = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_app_en", app_en, 0);
        check("t6_ob_we", ob_we, 0);
        check("t6_ib_re_done", {ib_re, done}, 0);
        exp_q.delete();
        addr_q.delete();
        infl = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rstn = 1'b1;
        @(negedge clk);
        check("t6_nocal_ready", cmd_ready, 0);
        check("t6_errs_clear", {err_unexp_rd, err_ob_ovf}, 0);
        @(posedge clk); #2 calib_done = 1'b1;
        @(negedge clk);
        check("t6_cal_ready", cmd_ready, 1);
        @(posedge clk); #2;
        spur_data = {8{32'hDEADBEEF}};
        spur_rv = 1'b1;
        @(posedge clk); #2 spur_rv = 1'b0;
        @(negedge clk);
        check("t6_unexp_rd", err_unexp_rd, 1);
        check("t6_ovf", err_ob_ovf, 0);
        check("t6_no_done", n_done, 0);
        clr_stats();
        send_cmd(1'b0, AW'(30'h100), 2);
        wait_done(lat);
        check("t6_post_ob_we", n_ob_we, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
